// File: rtl/mod_time_counter.sv
// Modulo-N up/down counter stage for the clock datapath, with registered carry/borrow/load_err pulses.
// Optional registered BCD digit outputs are enabled by defining DIGIT_BCD_EN.
module mod_time_counter #(
    parameter int WIDTH     = 6,
    parameter int MODULUS   = 60,
    parameter int RESET_VAL = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             inc,
    input  logic             dec,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             carry_out,
    output logic             borrow_out,
    output logic             load_err
`ifdef DIGIT_BCD_EN
    ,
    output logic [3:0]       bcd_tens,
    output logic [3:0]       bcd_ones
`endif
);

    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] RST_VAL = WIDTH'(RESET_VAL);
    localparam logic [WIDTH:0]   MOD_EXT = (WIDTH+1)'(MODULUS);

    logic [WIDTH-1:0] count_q, count_d;
    logic             carry_q, carry_d;
    logic             borrow_q, borrow_d;
    logic             load_err_q, load_err_d;

    logic             dec_op;
    logic [WIDTH-1:0] addend;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] rc;

    // Adding all-ones is the two's-complement -1, so one ripple chain serves both directions.
    assign dec_op = en & dec & ~inc;
    assign addend = {WIDTH{dec_op}} | WIDTH'(1);
    assign rc[0]  = 1'b0;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_ripple
            assign sum[gi] = count_q[gi] ^ addend[gi] ^ rc[gi];
            if (gi < WIDTH - 1) begin : g_carry
                assign rc[gi+1] = (count_q[gi] & addend[gi]) |
                                  (rc[gi] & (count_q[gi] ^ addend[gi]));
            end
        end
    endgenerate

    always_comb begin
        count_d    = count_q;
        carry_d    = 1'b0;
        borrow_d   = 1'b0;
        load_err_d = 1'b0;
        if (clr) begin
            count_d = RST_VAL;
        end else if (load) begin
            if ({1'b0, load_val} < MOD_EXT) begin
                count_d = load_val;
            end else begin
                count_d    = MAX_VAL;
                load_err_d = 1'b1;
            end
        end else if (en && inc && dec) begin
            count_d = count_q;
        end else if (en && inc) begin
            // >= also catches out-of-range values so they fold back to 0.
            if (count_q >= MAX_VAL) begin
                count_d = '0;
                carry_d = 1'b1;
            end else begin
                count_d = sum;
            end
        end else if (en && dec) begin
            if (count_q == '0) begin
                count_d  = MAX_VAL;
                borrow_d = 1'b1;
            end else begin
                count_d = sum;
            end
        end
    end

`ifdef DIGIT_BCD_EN
    localparam logic [3:0] RST_TENS = 4'(RESET_VAL / 10);
    localparam logic [3:0] RST_ONES = 4'(RESET_VAL % 10);

    generate
        if (MODULUS > 100) begin : g_bcd_range_check
            $error("mod_time_counter: BCD digits need MODULUS <= 100");
        end
    endgenerate

    logic [3:0] bcd_tens_q, bcd_tens_d;
    logic [3:0] bcd_ones_q, bcd_ones_d;

    always_comb begin
        bcd_tens_d = 4'(32'(count_d) / 32'd10);
        bcd_ones_d = 4'(32'(count_d) % 32'd10);
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q    <= RST_VAL;
            carry_q    <= 1'b0;
            borrow_q   <= 1'b0;
            load_err_q <= 1'b0;
`ifdef DIGIT_BCD_EN
            bcd_tens_q <= RST_TENS;
            bcd_ones_q <= RST_ONES;
`endif
        end else begin
            count_q    <= count_d;
            carry_q    <= carry_d;
            borrow_q   <= borrow_d;
            load_err_q <= load_err_d;
`ifdef DIGIT_BCD_EN
            bcd_tens_q <= bcd_tens_d;
            bcd_ones_q <= bcd_ones_d;
`endif
        end
    end

    assign count      = count_q;
    assign carry_out  = carry_q;
    assign borrow_out = borrow_q;
    assign load_err   = load_err_q;
`ifdef DIGIT_BCD_EN
    assign bcd_tens   = bcd_tens_q;
    assign bcd_ones   = bcd_ones_q;
`endif

endmodule

// File: tb/tb_mod_time_counter.sv
// Bench for mod_time_counter: directed vector table, async reset, randomized run against a
// modular-arithmetic model, and a seconds->hours cascade.
module tb_mod_time_counter;

    localparam int MOD = 60;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en, inc, dec, clr, load;
    logic [5:0] load_val;
    logic [5:0] count;
    logic       carry_out, borrow_out, load_err;
`ifdef DIGIT_BCD_EN
    logic [3:0] bcd_tens, bcd_ones;
    logic [3:0] lo_tens, lo_ones, hi_tens, hi_ones;
`endif

    // Cascade pair: lower modulo-60, upper modulo-24 incremented by the lower carry.
    logic       lo_en, lo_inc, lo_load, hi_en, hi_load;
    logic [5:0] lo_lv, lo_count;
    logic [4:0] hi_lv, hi_count;
    logic       lo_carry, lo_borrow, lo_lerr, hi_carry, hi_borrow, hi_lerr;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mod_time_counter #(.WIDTH(6), .MODULUS(60), .RESET_VAL(0)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .inc(inc), .dec(dec), .clr(clr),
        .load(load), .load_val(load_val), .count(count), .carry_out(carry_out),
        .borrow_out(borrow_out), .load_err(load_err)
`ifdef DIGIT_BCD_EN
        , .bcd_tens(bcd_tens), .bcd_ones(bcd_ones)
`endif
    );

    mod_time_counter #(.WIDTH(6), .MODULUS(60), .RESET_VAL(0)) u_lo (
        .clk(clk), .rst_n(rst_n), .en(lo_en), .inc(lo_inc), .dec(1'b0), .clr(1'b0),
        .load(lo_load), .load_val(lo_lv), .count(lo_count), .carry_out(lo_carry),
        .borrow_out(lo_borrow), .load_err(lo_lerr)
`ifdef DIGIT_BCD_EN
        , .bcd_tens(lo_tens), .bcd_ones(lo_ones)
`endif
    );

    mod_time_counter #(.WIDTH(5), .MODULUS(24), .RESET_VAL(0)) u_hi (
        .clk(clk), .rst_n(rst_n), .en(hi_en), .inc(lo_carry), .dec(1'b0), .clr(1'b0),
        .load(hi_load), .load_val(hi_lv), .count(hi_count), .carry_out(hi_carry),
        .borrow_out(hi_borrow), .load_err(hi_lerr)
`ifdef DIGIT_BCD_EN
        , .bcd_tens(hi_tens), .bcd_ones(hi_ones)
`endif
    );

    typedef struct {
        bit clr, load, en, inc, dec;
        int lv;
        int exp_count;
        bit exp_c, exp_b, exp_le;
    } vec_t;

    typedef struct {
        int  cnt;
        bit  c, b, le;
    } model_t;

    // Reference: plain modular arithmetic with the documented priority order.
    function automatic model_t model(int cur, bit c_clr, bit c_load, int lv,
                                     bit c_en, bit c_inc, bit c_dec);
        model_t r;
        r.cnt = cur; r.c = 0; r.b = 0; r.le = 0;
        if (c_clr) r.cnt = 0;
        else if (c_load) begin
            if (lv < MOD) r.cnt = lv;
            else begin r.cnt = MOD - 1; r.le = 1; end
        end else if (c_en && c_inc && c_dec) r.cnt = cur;
        else if (c_en && c_inc) begin
            r.cnt = (cur + 1) % MOD;
            r.c   = (cur == MOD - 1);
        end else if (c_en && c_dec) begin
            r.cnt = (cur + MOD - 1) % MOD;
            r.b   = (cur == 0);
        end
        return r;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_main(input string tag, input int ec, input bit c, input bit b, input bit le);
        chk({tag, " count"}, int'(count), ec);
        chk({tag, " carry_out"}, int'(carry_out), int'(c));
        chk({tag, " borrow_out"}, int'(borrow_out), int'(b));
        chk({tag, " load_err"}, int'(load_err), int'(le));
`ifdef DIGIT_BCD_EN
        chk({tag, " bcd_tens"}, int'(bcd_tens), ec / 10);
        chk({tag, " bcd_ones"}, int'(bcd_ones), ec % 10);
`endif
    endtask

    task automatic drive(input bit c_clr, input bit c_load, input int lv,
                         input bit c_en, input bit c_inc, input bit c_dec);
        clr = c_clr; load = c_load; load_val = 6'(lv);
        en = c_en; inc = c_inc; dec = c_dec;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    vec_t   vecs[$];
    model_t m;
    int     cur;

    initial begin
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        lo_en = 0; lo_inc = 0; lo_load = 0; lo_lv = '0;
        hi_en = 0; hi_load = 0; hi_lv = '0;

        vecs = '{
            '{clr:0, load:1, en:0, inc:0, dec:0, lv:45, exp_count:45, exp_c:0, exp_b:0, exp_le:0},
            '{clr:0, load:1, en:0, inc:0, dec:0, lv:63, exp_count:59, exp_c:0, exp_b:0, exp_le:1},
            '{clr:0, load:0, en:0, inc:0, dec:0, lv:0,  exp_count:59, exp_c:0, exp_b:0, exp_le:0},
            '{clr:0, load:0, en:1, inc:1, dec:0, lv:0,  exp_count:0,  exp_c:1, exp_b:0, exp_le:0},
            '{clr:0, load:0, en:1, inc:1, dec:0, lv:0,  exp_count:1,  exp_c:0, exp_b:0, exp_le:0},
            '{clr:0, load:0, en:1, inc:0, dec:1, lv:0,  exp_count:0,  exp_c:0, exp_b:0, exp_le:0},
            '{clr:0, load:0, en:1, inc:0, dec:1, lv:0,  exp_count:59, exp_c:0, exp_b:1, exp_le:0},
            '{clr:0, load:0, en:0, inc:1, dec:0, lv:0,  exp_count:59, exp_c:0, exp_b:0, exp_le:0},
            '{clr:1, load:1, en:1, inc:1, dec:0, lv:30, exp_count:0,  exp_c:0, exp_b:0, exp_le:0},
            '{clr:0, load:1, en:0, inc:0, dec:0, lv:20, exp_count:20, exp_c:0, exp_b:0, exp_le:0},
            '{clr:0, load:0, en:1, inc:1, dec:1, lv:0,  exp_count:20, exp_c:0, exp_b:0, exp_le:0},
            '{clr:0, load:1, en:1, inc:1, dec:0, lv:59, exp_count:59, exp_c:0, exp_b:0, exp_le:0},
            '{clr:0, load:0, en:1, inc:1, dec:0, lv:0,  exp_count:0,  exp_c:1, exp_b:0, exp_le:0},
            '{clr:0, load:1, en:0, inc:0, dec:0, lv:47, exp_count:47, exp_c:0, exp_b:0, exp_le:0},
            '{clr:0, load:0, en:1, inc:0, dec:1, lv:0,  exp_count:46, exp_c:0, exp_b:0, exp_le:0}
        };

        repeat (2) @(posedge clk);
        #1;
        chk_main("reset", 0, 0, 0, 0);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            drive(vecs[i].clr, vecs[i].load, vecs[i].lv, vecs[i].en, vecs[i].inc, vecs[i].dec);
            step();
            $display("vec %0d: count=%0d c=%0b b=%0b le=%0b", i, count, carry_out, borrow_out, load_err);
            chk_main($sformatf("vec%0d", i), vecs[i].exp_count, vecs[i].exp_c, vecs[i].exp_b, vecs[i].exp_le);
        end

        // Asynchronous reset in the middle of a clock period at count 37.
        drive(0, 1, 37, 0, 0, 0);
        step();
        chk("pre-reset count", int'(count), 37);
        drive(0, 0, 0, 1, 1, 0);
        #2;
        rst_n = 1'b0;
        #1;
        $display("async reset: count=%0d", count);
        chk_main("async_reset", 0, 0, 0, 0);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0);
        rst_n = 1'b1;
        step();
        chk_main("post_reset", 0, 0, 0, 0);

        // Randomized run against the model.
        cur = 0;
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 19) == 0, $urandom_range(0, 9) == 0, int'($urandom_range(0, 63)),
                  $urandom_range(0, 3) != 0, 1'($urandom), 1'($urandom));
            m = model(cur, clr, load, int'(load_val), en, inc, dec);
            step();
            $display("rnd %0d: clr=%0b ld=%0b lv=%0d en=%0b inc=%0b dec=%0b -> count=%0d",
                     i, clr, load, load_val, en, inc, dec, count);
            chk_main($sformatf("rnd%0d", i), m.cnt, m.c, m.b, m.le);
            cur = m.cnt;
        end
        drive(0, 0, 0, 0, 0, 0);

        // Cascade: lower 59, upper 23, one increment ripples over two cycles.
        lo_load = 1; lo_lv = 6'd59; hi_load = 1; hi_lv = 5'd23;
        step();
        lo_load = 0; hi_load = 0; hi_en = 1;
        chk("casc lo preset", int'(lo_count), 59);
        chk("casc hi preset", int'(hi_count), 23);
        lo_en = 1; lo_inc = 1;
        step();
        lo_en = 0; lo_inc = 0;
        $display("cascade T+1: lo=%0d lo_c=%0b hi=%0d hi_c=%0b", lo_count, lo_carry, hi_count, hi_carry);
        chk("casc T+1 lo count", int'(lo_count), 0);
        chk("casc T+1 lo carry", int'(lo_carry), 1);
        chk("casc T+1 hi count", int'(hi_count), 23);
        chk("casc T+1 hi carry", int'(hi_carry), 0);
        step();
        $display("cascade T+2: lo=%0d lo_c=%0b hi=%0d hi_c=%0b", lo_count, lo_carry, hi_count, hi_carry);
        chk("casc T+2 lo carry", int'(lo_carry), 0);
        chk("casc T+2 hi count", int'(hi_count), 0);
        chk("casc T+2 hi carry", int'(hi_carry), 1);
        step();
        chk("casc T+3 hi carry", int'(hi_carry), 0);
        chk("casc T+3 hi count", int'(hi_count), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mod_time_counter.md
Name: mod_time_counter

Overview:
Parametrised modulo-N up/down counter stage for the digital clock datapath. It is the sequential successor to the fixed-width ripple-carry adder: the next-state increment and decrement are built as a WIDTH-bit ripple-carry add of +1 or -1, with modulus wrap. Stages cascade through registered carry and borrow pulses to form seconds (60), minutes (60) and hours (24 or 12). Synchronous load and clear support time-set from the button/FSM logic.

Parameters:
WIDTH, 6, count register width; must satisfy 2^WIDTH >= MODULUS.
MODULUS, 60, count range 0..MODULUS-1; legal range 2..2^WIDTH.
RESET_VAL, 0, count value after reset and clr; must be < MODULUS.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
en  input  1  qualifies inc and dec; load and clr ignore en.
inc  input  1  count up by 1 this cycle (when en=1).
dec  input  1  count down by 1 this cycle (when en=1).
clr  input  1  synchronous clear to RESET_VAL.
load  input  1  synchronous load of load_val.
load_val  input  WIDTH  value to load.
count  output  WIDTH  registered current count.
carry_out  output  1  one-cycle pulse; count wrapped MODULUS-1 -> 0 on inc.
borrow_out  output  1  one-cycle pulse; count wrapped 0 -> MODULUS-1 on dec.
load_err  output  1  one-cycle pulse; load_val >= MODULUS was clamped.

Behaviour:
- Reset (rst_n=0, asynchronous, any time including mid-operation): count=RESET_VAL, carry_out=0, borrow_out=0, load_err=0, and BCD outputs = digits of RESET_VAL when DIGIT_BCD_EN is defined. Release is sampled on the next rising edge.
- Per-edge priority: clr > load > (en & inc & dec) > (en & inc) > (en & dec) > hold.
- clr: count<=RESET_VAL. No pulses; this applies even if load/inc/dec are also asserted.
- load: if load_val < MODULUS, count<=load_val and load_err<=0. Otherwise count<=MODULUS-1 and load_err<=1 for one cycle. No carry or borrow is generated.
- en & inc & dec both set: count holds; no pulses.
- inc: if count==MODULUS-1, count<=0 and carry_out<=1. Otherwise count<=count+1.
- dec: if count==0, count<=MODULUS-1 and borrow_out<=1. Otherwise count<=count-1.
- Pulses are registered. They are high for exactly the one cycle in which the new count is visible, and are 0 in every other cycle.
- Latency: 1 clock from the input edge to count and pulses. A cascaded stage driven by carry_out->inc (with en=1) updates one cycle after the lower stage; seconds->minutes->hours ripple therefore spans 2 cycles.
- If count is somehow >= MODULUS (not reachable via legal ops), the next inc wraps it to 0 with carry_out=1, and dec decrements normally.
- Arithmetic: unsigned, WIDTH bits. Compare against MODULUS-1 before adding so there is no overflow into bit WIDTH. No latches; a single always block holds the state.

Optional Feature:
DIGIT_BCD_EN:
- Defined: adds output ports bcd_tens[3:0] and bcd_ones[3:0]. These are registered BCD digits of the next count, updated on the same edge as count (zero extra latency). Requires MODULUS <= 100; a generate-time check flags violations.
- Undefined: the ports and logic are absent; the rest of the behaviour is identical.

Test Plan:
- Reset with MODULUS=60: rst_n low mid-count at count=37 -> count=0 immediately (asynchronous); all pulses 0; BCD 0/0.
- Wrap up: count=59, en=1, inc=1 for 1 cycle -> count=0, carry_out=1 for exactly 1 cycle; next cycle carry_out=0. Next inc -> count=1.
- Wrap down: count=0, en=1, dec=1 -> count=59, borrow_out=1 for 1 cycle. Also en=0, inc=1 -> count holds.
- Load and clamp: load=1, load_val=45 -> count=45, load_err=0. load_val=63 -> count=59, load_err=1 for 1 cycle. load and inc together -> load wins, carry_out=0.
- Priority and simultaneous events: count=59 with clr=1, load=1, inc=1 -> count=RESET_VAL, no pulses. count=20 with inc=dec=en=1 -> count=20, no pulses.
- Cascade: two instances, MODULUS 60 and 24. Lower at 59 and upper at 23, inc once -> lower 0 at T+1, upper 0 at T+2, upper carry_out at T+2. With DIGIT_BCD_EN, count=47 -> bcd_tens=4, bcd_ones=7 on the same cycle.
